nibble_serial_subtractor: RTL and testbench

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 130 +++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: computes a - b - bin four bits per cycle, LSB nibble first,
// with valid/ready handshakes on both sides and registered result flags.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               zero_q;
    logic               ovf_q;

    logic [3:0]         a_nib;
    logic [3:0]         nb_nib;
    logic [3:0]         g;
    logic [3:0]         p;
    logic [3:0]         c;
    logic               carry_d;
    logic [3:0]         sum_d;
    logic [WIDTH-1:0]   result_d;
    logic               last_nib;

    // 4-bit carry-lookahead adder on a + ~b + carry for the current nibble
    always_comb begin
        a_nib   = a_q[3:0];
        nb_nib  = ~b_q[3:0];
        g       = a_nib & nb_nib;
        p       = a_nib ^ nb_nib;
        c[0]    = carry_q;
        c[1]    = g[0] | (p[0] & c[0]);
        c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
        carry_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum_d   = p ^ c;
    end

    // Partial result shifts in from the top so the final nibble lands at the MSBs
    if (WIDTH > 4) begin : g_wide
        assign result_d = {sum_d, acc_q[WIDTH-1:4]};
    end else begin : g_narrow
        assign result_d = sum_d;
    end

    assign last_nib  = (cnt_q == CNT_W'(NIB - 1));
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ~bin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    acc_q   <= result_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        // a_q/b_q bit 3 holds the operand sign bits on the final nibble
                        diff_q  <= result_d;
                        bout_q  <= ~carry_d;
                        zero_q  <= (result_d == '0);
                        ovf_q   <= (a_nib[3] != b_q[3]) && (sum_d[3] != a_nib[3]);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor at WIDTH=32.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    nibble_serial_subtractor #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation: accept, latency, result, optional backpressure, handshake
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic op_bin, input logic [31:0] e_diff, input logic e_bout,
                          input logic e_zero, input logic e_ovf, input int hold);
        int n;
        @(negedge clk);
        a = op_a; b = op_b; bin = op_bin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom);
        check({tag, "_ready_in_run"}, 64'(in_ready), 64'd0);
        n = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n = i;
                break;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_diff"}, 64'(diff), 64'(e_diff));
        check({tag, "_bout"}, 64'(bout), 64'(e_bout));
        check({tag, "_zero"}, 64'(zero), 64'(e_zero));
        check({tag, "_ovf"},  64'(ovf),  64'(e_ovf));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_bp_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_bp_diff"}, 64'({bout, zero, ovf, diff}),
                  64'({e_bout, e_zero, e_ovf, e_diff}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_hs_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_hold"}, 64'(diff), 64'(e_diff));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_no_capture"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #1;
        check("reset_outputs", 64'({in_ready, out_valid, bout, zero, ovf, diff}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(in_ready), 64'd1);

        run_op("basic",   32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 0);
        run_op("wrap",    32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("sovf",    32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 0);
        run_op("zero",    32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 0);
        run_op("binonly", 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("negovf",  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 0);
        run_op("bp",      32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 5);

        // Reset asserted inside the third RUN cycle
        @(negedge clk);
        a = 32'h0000FFFF; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({in_ready, out_valid, bout, zero, ovf, diff}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_valid", 64'({out_valid, in_ready, diff}), 64'({1'b0, 1'b1, 32'd0}));

        run_op("post_rst", 32'h00000009, 32'h00000004, 1'b0, 32'h00000005, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
